// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opcodes, FSM states and flag-vector layout.
package alu_seq_pkg;

  // Operation codes; 13..15 are NOPs that still produce a (zero) result.
  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_PASSB = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_ADC   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_RSUB  = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_SHR   = 4'd10;
  localparam logic [3:0] OP_ASR   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_NOP_FIRST = 4'd13;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the registered flag vector.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int NFLAGS = 4;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier datapath: one partial-product step per cycle,
// WIDTH steps per product. Sequencing decisions are left to the parent.
module alu_seq_mul #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic                busy;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    mcand;
  logic [2*WIDTH-1:0]  prod;
  logic [WIDTH:0]      partial;
  logic [2*WIDTH-1:0]  prod_step;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (prod[0]) is set, then shift everything right.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    partial   = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0]) partial = partial + {1'b0, mcand};
    prod_step = {partial, prod[WIDTH-1:1]};
  end

  // The final step's value is presented combinationally so the parent can
  // register it on the same edge that completes the product.
  assign done    = busy && (cnt == LAST_STEP);
  assign product = prod_step;

  // Operand latch, step counter and partial-product register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      prod <= prod_step;
      cnt  <= cnt + 1'b1;
      if (cnt == LAST_STEP) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and a multi-cycle multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int MSB = WIDTH - 1;

  state_t              state, state_next;
  logic [NFLAGS-1:0]   flags;
  logic [NFLAGS-1:0]   alu_flags, mul_flags;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    alu_r;
  logic                alu_c, alu_v, alu_nop;
  logic                accept, start_mul, load_alu, mul_done;
  logic [2*WIDTH-1:0]  product;

  // Accept only in IDLE and only if the output slot is free or being drained.
  assign in_ready  = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (op == OP_MUL);
  assign load_alu  = accept && (op != OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  // Single-cycle result and flags; arithmetic runs at WIDTH+1 bits so the
  // top bit is the carry (or borrow for subtraction).
  always_comb begin
    sum     = '0;
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_nop = 1'b0;
    case (op)
      OP_PASSA: alu_r = a;
      OP_PASSB: alu_r = b;
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & carry_in};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum   = {1'b0, a} - {1'b0, b};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[MSB] != b[MSB]) && (alu_r[MSB] != a[MSB]);
      end
      OP_RSUB: begin
        sum   = {1'b0, b} - {1'b0, a};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[MSB] != b[MSB]) && (alu_r[MSB] != b[MSB]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_SHL: begin alu_r = a << 1;                 alu_c = a[MSB]; end
      OP_SHR: begin alu_r = a >> 1;                 alu_c = a[0];   end
      OP_ASR: begin alu_r = {a[MSB], a[WIDTH-1:1]}; alu_c = a[0];   end
      OP_MUL: alu_r = '0;
      default: alu_nop = 1'b1;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_Z] = !alu_nop && (alu_r == '0);
    alu_flags[FLAG_N] = alu_r[MSB];
    alu_flags[FLAG_V] = alu_v;
  end

  // Multiply flags: zero/negative over the full double-width product.
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (product == '0);
    mul_flags[FLAG_N] = product[2*WIDTH-1];
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> MUL on a multiply, MUL -> DONE on the last
  // step, DONE -> IDLE once the consumer takes the product.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_mul) state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output registers: loaded by a single-cycle op or by the finishing
  // multiply; out_valid clears when the result is consumed with no reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      result    <= alu_r;
      result_hi <= '0;
      flags     <= alu_flags;
    end else if (start_mul) begin
      out_valid <= 1'b0;
    end else if ((state == ST_MUL) && mul_done) begin
      out_valid <= 1'b1;
      result    <= product[WIDTH-1:0];
      result_hi <= product[2*WIDTH-1:WIDTH];
      flags     <= mul_flags;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign flag_c = flags[FLAG_C];
  assign flag_z = flags[FLAG_Z];
  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with hand-computed expectations.
module tb_alu_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result, result_hi;
  logic             flag_c, flag_z, flag_n, flag_v;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Expected flags are given as {v, n, z, c}.
  task automatic check_out(input string tag, input logic [7:0] exp_r,
                           input logic [7:0] exp_hi, input logic [3:0] exp_f);
    check({tag, " valid"},  {31'd0, out_valid}, 32'd1);
    check({tag, " result"}, {24'd0, result},    {24'd0, exp_r});
    check({tag, " hi"},     {24'd0, result_hi}, {24'd0, exp_hi});
    check({tag, " flags"},  {28'd0, flag_v, flag_n, flag_z, flag_c}, {28'd0, exp_f});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
  endtask

  int  lat;
  logic all_busy;
  logic stable;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 4'd0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst in_ready",  {31'd0, in_ready},  32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result",    {24'd0, result},    32'd0);
    check("rst flags",     {28'd0, flag_v, flag_n, flag_z, flag_c}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops with the consumer always ready.
    drive(4'd2, 8'h7F, 8'h01); step();
    check_out("ADD 7F+01", 8'h80, 8'h00, 4'b1100);
    check("ADD in_ready", {31'd0, in_ready}, 32'd1);
    drive(4'd4, 8'h00, 8'h01); step();
    check_out("SUB 00-01", 8'hFF, 8'h00, 4'b0101);
    drive(4'd6, 8'hF0, 8'h3C); step();
    check_out("AND F0&3C", 8'h30, 8'h00, 4'b0000);
    in_valid = 1'b0; step();
    check("drained out_valid", {31'd0, out_valid}, 32'd0);

    // ADC wrapping to zero.
    drive(4'd3, 8'hFF, 8'h00); carry_in = 1'b1; step();
    check_out("ADC FF+00+1", 8'h00, 8'h00, 4'b0011);
    carry_in = 1'b0;

    // Shifts of 0x81.
    drive(4'd9, 8'h81, 8'h00); step();
    check_out("SHL 81", 8'h02, 8'h00, 4'b0001);
    drive(4'd10, 8'h81, 8'h00); step();
    check_out("SHR 81", 8'h40, 8'h00, 4'b0001);
    drive(4'd11, 8'h81, 8'h00); step();
    check_out("ASR 81", 8'hC0, 8'h00, 4'b0101);

    // NOP opcode: zero result, all flags clear, still valid.
    drive(4'd14, 8'h55, 8'hAA); step();
    check_out("NOP 14", 8'h00, 8'h00, 4'b0000);

    // MUL FF*FF: 9 cycles with in_ready low, product 0xFE01.
    drive(4'd12, 8'hFF, 8'hFF); step();
    in_valid = 1'b0;
    lat = 0;
    all_busy = 1'b1;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0) all_busy = 1'b0;
      step();
      lat++;
    end
    if (in_ready !== 1'b0) all_busy = 1'b0;
    check("MUL latency edges", lat, 32'd8);
    check("MUL in_ready low", {31'd0, all_busy}, 32'd1);
    check_out("MUL FFxFF", 8'h01, 8'hFE, 4'b0100);
    step();
    check("MUL done in_ready", {31'd0, in_ready}, 32'd1);
    check("MUL done out_valid", {31'd0, out_valid}, 32'd0);

    // MUL 00*37: zero product.
    drive(4'd12, 8'h00, 8'h37); step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("MUL0 latency edges", lat, 32'd8);
    check_out("MUL 00x37", 8'h00, 8'h00, 4'b0010);
    step();

    // Backpressure: RSUB result must hold while out_ready is low.
    out_ready = 1'b0;
    drive(4'd5, 8'h05, 8'h03); step();
    check_out("RSUB 03-05", 8'hFE, 8'h00, 4'b0101);
    drive(4'd2, 8'h01, 8'h01);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 8'hFE ||
          result_hi !== 8'h00 || {flag_v, flag_n, flag_z, flag_c} !== 4'b0101)
        stable = 1'b0;
      step();
    end
    check("stall stable", {31'd0, stable}, 32'd1);
    check_out("stall hold", 8'hFE, 8'h00, 4'b0101);
    out_ready = 1'b1;
    #1;
    check("release in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_out("ADD after stall", 8'h02, 8'h00, 4'b0000);
    in_valid = 1'b0; step();

    // Reset in the middle of a multiply aborts it.
    drive(4'd12, 8'hFF, 8'hFF); step();
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort result",    {24'd0, result},    32'd0);
    check("abort hi",        {24'd0, result_hi}, 32'd0);
    check("abort flags",     {28'd0, flag_v, flag_n, flag_z, flag_c}, 32'd0);
    check("abort in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("abort release in_ready", {31'd0, in_ready}, 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) stable = 1'b0;
      step();
    end
    check("abort no output", {31'd0, stable}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 8-bit combinational ALU in the datapath. Operands of width WIDTH are accepted through a valid/ready handshake. Results and status flags (carry, zero, negative, overflow) are registered. An unsigned multiply is computed by a multi-cycle shift-add FSM. It sits between the register file/accumulators and the writeback stage, so the control unit can stall cleanly on either side.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2).
CNT_W, $clog2(WIDTH)+1, width of the internal multiply step counter.

Ports:
Clock      input   1        rising-edge clock
Reset_n    input   1        asynchronous, active-low reset
in_valid   input   1        op/a/b/carry_in are valid this cycle
in_ready   output  1        block can accept an operation this cycle
op         input   4        operation code (alu_seq_pkg)
a          input   WIDTH    operand A
b          input   WIDTH    operand B
carry_in   input   1        carry for ADC
out_valid  output  1        result and flags are valid
out_ready  input   1        consumer accepts the result
result     output  WIDTH    result (low half for MUL)
result_hi  output  WIDTH    high half for MUL; 0 for all other ops
flag_c     output  1        carry / borrow / shifted-out bit
flag_z     output  1        result (and result_hi for MUL) == 0
flag_n     output  1        result[WIDTH-1]; result_hi[WIDTH-1] for MUL
flag_v     output  1        signed overflow (ADD/ADC/SUB/RSUB only, else 0)

Behaviour:
- Reset (Reset_n=0, async): state=IDLE, out_valid=0, result=0, result_hi=0, all flags=0, counter=0. in_ready=0 while reset is asserted. Reset mid-multiply aborts the operation with no output.
- Handshake: a transfer occurs when in_valid && in_ready; the result is consumed when out_valid && out_ready. Outputs hold stable while out_valid=1 and out_ready=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows one single-cycle op per clock with no bubble.
- Op encoding:
  - 0 PASSA=a; 1 PASSB=b
  - 2 ADD=a+b; 3 ADC=a+b+carry_in
  - 4 SUB=a-b; 5 RSUB=b-a
  - 6 AND; 7 OR; 8 XOR
  - 9 SHL=a<<1; 10 SHR=a>>1 logical; 11 ASR=a>>>1
  - 12 MUL unsigned, a*b into {result_hi,result}
  - 13-15 NOP: result=0, all flags=0, out_valid still asserted.
- Arithmetic is computed at WIDTH+1 bits. flag_c is the bit WIDTH of the sum.
- For SUB/RSUB, flag_c=1 indicates a borrow (minuend < subtrahend unsigned).
- flag_v:
  - ADD/ADC: operands have the same sign and the result sign differs.
  - SUB/RSUB: operands have different signs and the result sign differs from the minuend.
- Shift flag_c: SHL gives a[WIDTH-1]; SHR/ASR give a[0]. Logic ops give flag_c=0.
- Latency of single-cycle ops: accepted at edge k, out_valid=1 after edge k (visible in cycle k+1).
- States: IDLE, MUL, DONE.
  - IDLE: a single-cycle op stays in IDLE and loads the output registers directly.
  - IDLE -> MUL on accepting op 12. Operands are latched, the accumulator and counter are cleared, and out_valid drops if the previous result is consumed.
  - MUL: one shift-add step per cycle for exactly WIDTH cycles; in_ready=0 throughout.
  - MUL -> DONE after step WIDTH: {result_hi,result} and flags are loaded, out_valid=1.
  - DONE -> IDLE when out_ready=1. No input is accepted in DONE.
- MUL latency is WIDTH+1 cycles from accept to out_valid. MUL flags: c=0, v=0.
- Simultaneous consume and accept in IDLE: the new result replaces the old one, and out_valid stays 1.
- op and operands are ignored when no transfer occurs.

Decomposition:
- alu_seq_pkg: opcode localparams (OP_PASSA..OP_MUL, OP_NOP range), the FSM state encoding, and a flag-vector bit-index constant.
- One natural sub-module, alu_seq_mul: the shift-add multiplier datapath (start, done, operands, 2*WIDTH product). Control stays in alu_seq.

Test Plan:
1. Reset mid-MUL: WIDTH=8, issue MUL, drop Reset_n in cycle 4 -> out_valid=0, result=0, all flags=0, and in_ready=1 one cycle after release.
2. Back-to-back ops with out_ready=1: ADD 0x7F+0x01, then SUB 0x00-0x01, then AND 0xF0&0x3C on consecutive cycles -> the three results follow one per cycle:
   - 0x80 with v=1, n=1, c=0
   - 0xFF with c=1, n=1, v=0
   - 0x30 with all flags 0
3. ADC 0xFF+0x00+carry_in=1 -> result 0x00, c=1, z=1, v=0.
4. Shifts on a=0x81:
   - SHL -> 0x02, c=1
   - SHR -> 0x40, c=1
   - ASR -> 0xC0, c=1, n=1
5. MUL 0xFF*0xFF -> in_ready=0 for 9 cycles, then result_hi=0xFE, result=0x01, z=0, n=1. MUL 0x00*0x37 -> z=1.
6. Backpressure: out_ready=0 for 5 cycles after an RSUB (a=0x05, b=0x03, giving 0xFE with c=1) -> result and flags stay stable, and in_ready=0 for the whole stall. Raising out_ready with in_valid high accepts the next op in the same cycle.
